// File: rtl/fpt_veto_hub_mc.sv
// Multi-lane FPT veto hub: per-lane saturated motor correction and hold-timed veto,
// with new veto events queued and reported as 3-byte 8N1 UART frames.
module fpt_veto_hub_mc #(
  parameter int CHANNELS     = 4,
  parameter int DATA_W       = 16,
  parameter int CORR_SHIFT   = 2,
  parameter int VETO_THRESH  = 4096,
  parameter int VETO_HOLD    = 1024,
  parameter int CLKS_PER_BIT = 1233,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk_142mhz,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   sensor_scrape,
  input  logic [CHANNELS-1:0]          sensor_valid,
  input  logic [CHANNELS*DATA_W-1:0]   motor_command,
  input  logic                         clear_overflow,
  output logic [CHANNELS*DATA_W-1:0]   motor_correction,
  output logic [CHANNELS-1:0]          veto_out,
  output logic                         veto_any,
  output logic [1:0]                   attention_level,
  output logic                         led_red,
  output logic                         led_green,
  output logic                         uart_tx,
  output logic                         evt_overflow
);

  localparam int HW = (VETO_HOLD > 2) ? $clog2(VETO_HOLD) : 1;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 4 + 2 + 8;
  localparam logic [DATA_W:0] THRESH_V  = (DATA_W+1)'(VETO_THRESH);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(VETO_HOLD - 1);
  localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [DATA_W-1:0] sat_w(input logic signed [DATA_W+1:0] v);
    if (v > $signed({3'b000, {(DATA_W-1){1'b1}}})) begin
      sat_w = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < $signed({3'b111, {(DATA_W-1){1'b0}}})) begin
      sat_w = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_w = v[DATA_W-1:0];
    end
  endfunction

  logic signed [DATA_W:0]   err_s      [CHANNELS];
  logic        [DATA_W:0]   mag_s      [CHANNELS];
  logic        [7:0]        mag_byte_s [CHANNELS];
  logic        [DATA_W-1:0] corr_s     [CHANNELS];
  logic [CHANNELS-1:0]      trig_s, rise_s, deq_s;
  logic [HW-1:0]            hold_r     [CHANNELS];
  logic [7:0]               mag_r      [CHANNELS];
  logic [CHANNELS-1:0]      pend_r;

  logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0]    wr_ptr_r, rd_ptr_r;
  logic           empty_s, full_s, push_s, pop_s;
  logic [3:0]     sel_s;
  logic [7:0]     sel_mag_s;
  logic [4:0]     vcount_s;
  logic [1:0]     attn_next_s;
  logic [EW-1:0]  head_s;

  state_t         state_r;
  logic [CW-1:0]  clk_cnt_r;
  logic [2:0]     bit_idx_r;
  logic [1:0]     byte_idx_r;
  logic [7:0]     shift_r;
  logic [15:0]    frame_r;
  logic           bit_end_s;

  // Per-lane error, magnitude, saturated correction and trigger decode
  always_comb begin
    logic [DATA_W-1:0]        sens_v, cmd_v;
    logic signed [DATA_W:0]   shr_v;
    logic signed [DATA_W+1:0] wide_v;
    sens_v = '0;
    cmd_v  = '0;
    shr_v  = '0;
    wide_v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sens_v        = sensor_scrape[i*DATA_W +: DATA_W];
      cmd_v         = motor_command[i*DATA_W +: DATA_W];
      err_s[i]      = {sens_v[DATA_W-1], sens_v} - {cmd_v[DATA_W-1], cmd_v};
      mag_s[i]      = err_s[i][DATA_W] ? -err_s[i] : err_s[i];
      mag_byte_s[i] = mag_s[i][DATA_W] ? 8'hFF : mag_s[i][DATA_W-1 -: 8];
      shr_v         = err_s[i] >>> CORR_SHIFT;
      wide_v        = {cmd_v[DATA_W-1], cmd_v[DATA_W-1], cmd_v} - {shr_v[DATA_W], shr_v};
      corr_s[i]     = sat_w(wide_v);
      trig_s[i]     = sensor_valid[i] & (mag_s[i] > THRESH_V);
      rise_s[i]     = trig_s[i] & ~veto_out[i];
    end
  end

  // Lowest pending lane, vetoed-lane count and FIFO handshake
  always_comb begin
    sel_s     = 4'd0;
    sel_mag_s = 8'd0;
    vcount_s  = 5'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_r[i]) begin
        sel_s     = 4'(i);
        sel_mag_s = mag_r[i];
      end else begin
        sel_s     = sel_s;
        sel_mag_s = sel_mag_s;
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      vcount_s = vcount_s + 5'(veto_out[i]);
    end
    // The entry carries the attention level the register takes at this same edge.
    attn_next_s = (vcount_s > 5'd3) ? 2'd3 : vcount_s[1:0];
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    bit_end_s   = (clk_cnt_r == CLK_LAST);
    pop_s       = ~empty_s & ((state_r == S_IDLE) |
                              ((state_r == S_STOP) & bit_end_s & (byte_idx_r == 2'd2)));
    push_s      = (|pend_r) & (~full_s | pop_s);
    for (int i = 0; i < CHANNELS; i++) begin
      deq_s[i] = push_s & (sel_s == 4'(i));
    end
    head_s = fifo_mem[rd_ptr_r[PW-1:0]];
  end

  assign led_red   = veto_any;
  assign led_green = ~veto_any & (|sensor_valid);

  // Lane state: correction, veto hold timer, pending event and captured magnitude
  always_ff @(posedge clk_142mhz) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        motor_correction[i*DATA_W +: DATA_W] <= '0;
        veto_out[i] <= 1'b0;
        hold_r[i]   <= '0;
        pend_r[i]   <= 1'b0;
        mag_r[i]    <= 8'd0;
      end else begin
        if (sensor_valid[i]) begin
          motor_correction[i*DATA_W +: DATA_W] <= veto_out[i] ? '0 : corr_s[i];
        end
        if (trig_s[i]) begin
          veto_out[i] <= 1'b1;
          hold_r[i]   <= HOLD_INIT;
        end else if (hold_r[i] != '0) begin
          hold_r[i] <= hold_r[i] - 1'b1;
        end else begin
          veto_out[i] <= 1'b0;
        end
        pend_r[i] <= (pend_r[i] & ~deq_s[i]) | rise_s[i];
        if (rise_s[i]) begin
          mag_r[i] <= mag_byte_s[i];
        end
      end
    end
  end

  // Summary outputs and sticky overflow (an event lost only if its pend is not drained now)
  always_ff @(posedge clk_142mhz) begin
    if (rst) begin
      veto_any        <= 1'b0;
      attention_level <= 2'd0;
      evt_overflow    <= 1'b0;
    end else begin
      veto_any        <= |veto_out;
      attention_level <= attn_next_s;
      if (|(rise_s & pend_r & ~deq_s)) begin
        evt_overflow <= 1'b1;
      end else if (clear_overflow) begin
        evt_overflow <= 1'b0;
      end
    end
  end

  // Event FIFO storage
  always_ff @(posedge clk_142mhz) begin
    if (push_s) begin
      fifo_mem[wr_ptr_r[PW-1:0]] <= {sel_s, attn_next_s, sel_mag_s};
    end
  end

  // Event FIFO pointers
  always_ff @(posedge clk_142mhz) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // UART frame sequencer: A5, {attn,00,ch}, magnitude byte; 8N1, LSB first
  always_ff @(posedge clk_142mhz) begin
    if (rst) begin
      state_r    <= S_IDLE;
      uart_tx    <= 1'b1;
      clk_cnt_r  <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 8'd0;
      frame_r    <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            state_r    <= S_START;
            uart_tx    <= 1'b0;
            clk_cnt_r  <= '0;
            byte_idx_r <= 2'd0;
            shift_r    <= 8'hA5;
            frame_r    <= {head_s[7:0], head_s[9:8], 2'b00, head_s[13:10]};
          end else begin
            uart_tx <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            state_r   <= S_DATA;
            uart_tx   <= shift_r[0];
            shift_r   <= shift_r >> 1;
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              state_r <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              uart_tx   <= shift_r[0];
              shift_r   <= shift_r >> 1;
              bit_idx_r <= bit_idx_r + 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= '0;
            if (byte_idx_r != 2'd2) begin
              state_r    <= S_START;
              uart_tx    <= 1'b0;
              byte_idx_r <= byte_idx_r + 1'b1;
              shift_r    <= frame_r[7:0];
              frame_r    <= frame_r >> 8;
            end else if (pop_s) begin
              state_r    <= S_START;
              uart_tx    <= 1'b0;
              byte_idx_r <= 2'd0;
              shift_r    <= 8'hA5;
              frame_r    <= {head_s[7:0], head_s[9:8], 2'b00, head_s[13:10]};
            end else begin
              state_r <= S_IDLE;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpt_veto_hub_mc.sv
// Directed bench for fpt_veto_hub_mc: correction, veto hold, UART frames, overflow, reset.
module tb_fpt_veto_hub_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] sensor_scrape, motor_command, motor_correction;
  logic [3:0]  sensor_valid, veto_out;
  logic        clear_overflow, veto_any, led_red, led_green, uart_tx, evt_overflow;
  logic [1:0]  attention_level;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] val;
    int         t;
    logic       ok;
  } rx_t;
  rx_t rxq[$];

  fpt_veto_hub_mc #(
    .CHANNELS(4), .DATA_W(16), .CORR_SHIFT(2), .VETO_THRESH(4096),
    .VETO_HOLD(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk_142mhz(clk), .rst(rst), .sensor_scrape(sensor_scrape),
    .sensor_valid(sensor_valid), .motor_command(motor_command),
    .clear_overflow(clear_overflow), .motor_correction(motor_correction),
    .veto_out(veto_out), .veto_any(veto_any), .attention_level(attention_level),
    .led_red(led_red), .led_green(led_green), .uart_tx(uart_tx),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int ln, input logic [15:0] s, input logic [15:0] c);
    sensor_scrape[ln*16 +: 16] = s;
    motor_command[ln*16 +: 16] = c;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rxq.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rx_bytes_arrived", 32'(rxq.size() >= n), 32'd1);
  endtask

  task automatic chk_frame(input int b, input logic [7:0] e1, input logic [7:0] e2);
    if (rxq.size() >= b + 3) begin
      chk("frame_byte0", 32'(rxq[b].val), 32'h A5);
      chk("frame_byte1", 32'(rxq[b+1].val), 32'(e1));
      chk("frame_byte2", 32'(rxq[b+2].val), 32'(e2));
      chk("frame_8n1", 32'({rxq[b].ok, rxq[b+1].ok, rxq[b+2].ok}), 32'h7);
      chk("frame_b1_offset", 32'(rxq[b+1].t - rxq[b].t), 32'd40);
      chk("frame_b2_offset", 32'(rxq[b+2].t - rxq[b].t), 32'd80);
    end
  endtask

  // UART receiver: mid-bit sampling at 4 clocks per bit
  initial begin : rx_mon
    logic [7:0] v;
    int         t0;
    logic       st, sp;
    forever begin
      tick();
      if (uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (2) tick();
        st = uart_tx;
        for (int b = 0; b < 8; b++) begin
          repeat (4) tick();
          v[b] = uart_tx;
        end
        repeat (4) tick();
        sp = uart_tx;
        rxq.push_back('{val: v, t: t0, ok: (st === 1'b0) && (sp === 1'b1)});
      end
    end
  end

  initial begin : stim
    int hi;
    int zeros;
    rst = 1'b1;
    sensor_scrape = '0;
    motor_command = '0;
    sensor_valid = 4'b0000;
    clear_overflow = 1'b0;
    repeat (3) tick();
    chk("rst_corr", 32'(motor_correction == 64'd0), 32'd1);
    chk("rst_veto", 32'(veto_out), 32'd0);
    chk("rst_veto_any", 32'(veto_any), 32'd0);
    chk("rst_attn", 32'(attention_level), 32'd0);
    chk("rst_uart", 32'(uart_tx), 32'd1);
    chk("rst_ovf", 32'(evt_overflow), 32'd0);
    rst = 1'b0;
    tick();

    // 1. correction 1000 - (400 >>> 2) = 900
    set_lane(0, 16'd1400, 16'd1000);
    sensor_valid = 4'b0001;
    #1;
    chk("led_green", 32'(led_green), 32'd1);
    tick();
    sensor_valid = 4'b0000;
    chk("corr0", 32'(motor_correction[15:0]), 32'd900);
    chk("corr_no_veto", 32'(veto_out), 32'd0);
    chk("corr_uart_idle", 32'(uart_tx), 32'd1);
    set_lane(0, 16'd0, 16'd0);
    tick();
    chk("corr0_hold", 32'(motor_correction[15:0]), 32'd900);

    // 2a. single trigger: 8 cycles of veto, attention one cycle later
    set_lane(2, 16'd5000, 16'd0);
    sensor_valid = 4'b0100;
    tick();
    sensor_valid = 4'b0000;
    chk("attn_lag", 32'(attention_level), 32'd0);
    hi = veto_out[2] ? 1 : 0;
    for (int k = 1; k < 12; k++) begin
      tick();
      if (veto_out[2]) hi++;
      if (k == 1) begin
        chk("attn_one", 32'(attention_level), 32'd1);
        chk("led_red", 32'(led_red), 32'd1);
      end
    end
    chk("veto_len_single", 32'(hi), 32'd8);

    // 3. frame for that event
    wait_rx(3, 300);
    chk_frame(0, 8'h42, 8'h13);
    repeat (10) tick();

    // 2b. retrigger on hold cycle 5 extends to 12 cycles, one frame only
    rxq.delete();
    sensor_valid = 4'b0100;
    tick();
    sensor_valid = 4'b0000;
    hi = veto_out[2] ? 1 : 0;
    repeat (3) begin
      tick();
      if (veto_out[2]) hi++;
    end
    sensor_valid = 4'b0100;
    tick();
    sensor_valid = 4'b0000;
    if (veto_out[2]) hi++;
    repeat (16) begin
      tick();
      if (veto_out[2]) hi++;
    end
    chk("veto_len_retrig", 32'(hi), 32'd12);
    repeat (300) tick();
    chk("retrig_one_frame", 32'(rxq.size()), 32'd3);

    // 4. all lanes at once, frames in lane order back to back
    rxq.delete();
    for (int ln = 0; ln < 4; ln++) set_lane(ln, 16'd6000, 16'd0);
    sensor_valid = 4'b1111;
    tick();
    sensor_valid = 4'b0000;
    chk("all_veto", 32'(veto_out), 32'hF);
    tick();
    chk("attn_sat", 32'(attention_level), 32'd3);
    wait_rx(12, 700);
    for (int f = 0; f < 4; f++) begin
      chk_frame(3 * f, 8'hC0 | 8'(f), 8'h17);
      if (f > 0 && rxq.size() >= 12) chk("frame_spacing", 32'(rxq[3*f].t - rxq[3*f-3].t), 32'd120);
    end
    chk("no_ovf_simul", 32'(evt_overflow), 32'd0);
    repeat (10) tick();

    // 5. overflow: lane3 frame busy, 4 lane1 events fill FIFO, 5th pends, 6th is lost
    rxq.delete();
    sensor_valid = 4'b1000;
    tick();
    sensor_valid = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      repeat (11) tick();
      sensor_valid = 4'b0010;
      tick();
      sensor_valid = 4'b0000;
      chk("ovf_after_event", 32'(evt_overflow), 32'(e == 6));
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(evt_overflow), 32'd0);

    set_lane(0, 16'h7FFF, 16'h8000);
    sensor_valid = 4'b0001;
    tick();
    sensor_valid = 4'b0000;
    chk("sat_neg", 32'(motor_correction[15:0]), 32'h8000);
    set_lane(0, 16'd1000, 16'd1000);
    sensor_valid = 4'b0001;
    tick();
    sensor_valid = 4'b0000;
    chk("vetoed_corr_zero", 32'(motor_correction[15:0]), 32'd0);
    set_lane(2, 16'd4096, 16'd0);
    sensor_valid = 4'b0100;
    tick();
    sensor_valid = 4'b0000;
    chk("thresh_equal_no_veto", 32'(veto_out[2]), 32'd0);
    chk("corr2_thresh", 32'(motor_correction[47:32]), 32'h FC00);
    set_lane(2, 16'h8000, 16'h7FFF);
    sensor_valid = 4'b0100;
    tick();
    sensor_valid = 4'b0000;
    chk("sat_pos", 32'(motor_correction[47:32]), 32'h7FFF);
    chk("sat_pos_veto", 32'(veto_out[2]), 32'd1);

    // 6. reset during DATA of byte 1 abandons the frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    rxq.delete();
    set_lane(2, 16'd5000, 16'd0);
    sensor_valid = 4'b0100;
    tick();
    sensor_valid = 4'b0000;
    repeat (51) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_uart", 32'(uart_tx), 32'd1);
    chk("midrst_veto", 32'(veto_out), 32'd0);
    chk("midrst_veto_any", 32'(veto_any), 32'd0);
    chk("midrst_attn", 32'(attention_level), 32'd0);
    chk("midrst_corr", 32'(motor_correction == 64'd0), 32'd1);
    chk("midrst_ovf", 32'(evt_overflow), 32'd0);
    zeros = 0;
    repeat (200) begin
      tick();
      if (uart_tx !== 1'b1) zeros++;
    end
    chk("midrst_line_idle", 32'(zeros), 32'd0);
    rxq.delete();
    set_lane(1, 16'd5000, 16'd0);
    sensor_valid = 4'b0010;
    tick();
    sensor_valid = 4'b0000;
    wait_rx(3, 300);
    chk_frame(0, 8'h41, 8'h13);
    repeat (200) tick();
    chk("post_rst_one_frame", 32'(rxq.size()), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
